// File: rtl/wfifo_wr_arbiter_if.sv
// Write-side bus between NREQ requesters, the round-robin arbiter and the FIFO write port.
// The master modport is the arbiter; the slave modport is the requester/FIFO side.
interface wfifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       wreq;
  logic [NREQ*DSIZE-1:0] wdata_in;
  logic [NREQ-1:0]       wgnt;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [OW-1:0]         wowner;
  logic                  wbusy;

  modport master (
    input  wreq, wdata_in, wfull,
    output wgnt, winc, wdata, wowner, wbusy
  );

  modport slave (
    output wreq, wdata_in, wfull,
    input  wgnt, winc, wdata, wowner, wbusy
  );
endinterface

// File: rtl/wfifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters in the wclk domain.
// Define WFIFO_ARB_BURST_LOCK_EN to let an owner write up to BURST words per grant.
module wfifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  wfifo_wr_arbiter_if.master  bus
);
  localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
`ifdef WFIFO_ARB_BURST_LOCK_EN
  localparam int BURST_EFF = BURST;
`else
  localparam int BURST_EFF = 1;
`endif
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(BURST_EFF - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_reg;
  logic [OW-1:0]   rr_ptr_reg;
  logic [OW-1:0]   owner_reg;
  logic [BCW-1:0]  bcnt_reg;

  logic [DSIZE-1:0] word [NREQ];
  logic [OW-1:0]    sel;
  logic             found;
  logic [OW-1:0]    idx_w;
  int               idx;
  logic             winc_int;
  logic             release_now;
  logic [OW-1:0]    rr_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
      assign word[gi] = bus.wdata_in[gi*DSIZE +: DSIZE];
    end
  endgenerate

  // First set request at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = OW'(idx);
      if (!found && bus.wreq[idx_w]) begin
        found = 1'b1;
        sel   = idx_w;
      end
    end
  end

  assign winc_int    = (state_reg == OWN) && bus.wreq[owner_reg] && !bus.wfull;
  assign release_now = (state_reg == OWN) &&
                       (!bus.wreq[owner_reg] || (winc_int && (bcnt_reg == BCNT_LAST)));
  assign rr_next     = (owner_reg == OW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;

  assign bus.winc   = winc_int;
  assign bus.wgnt   = NREQ'(winc_int) << owner_reg;
  assign bus.wdata  = (state_reg == OWN) ? word[owner_reg] : '0;
  assign bus.wowner = owner_reg;
  assign bus.wbusy  = (state_reg == OWN);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      bcnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            owner_reg <= sel;
            bcnt_reg  <= '0;
            state_reg <= OWN;
          end
        end
        OWN: begin
          // A wfull stall leaves bcnt and ownership untouched.
          if (winc_int) bcnt_reg <= bcnt_reg + 1'b1;
          if (release_now) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= rr_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
